// File: rtl/spmv_host_bridge_if.sv
// spmv_host_bridge_if: host stream, result stream and SRAM A/B port bundle of the SpMV host bridge.
// slave is the bridge side; master is the host/SRAM/controller side.
interface spmv_host_bridge_if #(
    parameter int ADDR_W = 5,
    parameter int LINE_W = 256,
    parameter int WORD_W = 32
);
    logic              i_in_valid;
    logic              o_in_ready;
    logic [WORD_W-1:0] i_in_data;
    logic              i_in_last;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [WORD_W-1:0] o_out_data;
    logic              o_out_last;
    logic              o_own_sram;
    logic [ADDR_W-1:0] o_addr_A;
    logic              o_wr_en_A;
    logic [LINE_W-1:0] o_write_data_A;
    logic [ADDR_W-1:0] o_addr_B;
    logic [LINE_W-1:0] i_read_data_B;
    logic              i_ops_done;
    logic              o_busy;
    logic              o_overflow;
    logic              o_timeout;

    modport slave (
        input  i_in_valid, i_in_data, i_in_last, i_out_ready, i_read_data_B, i_ops_done,
        output o_in_ready, o_out_valid, o_out_data, o_out_last, o_own_sram, o_addr_A,
               o_wr_en_A, o_write_data_A, o_addr_B, o_busy, o_overflow, o_timeout
    );
    modport master (
        output i_in_valid, i_in_data, i_in_last, i_out_ready, i_read_data_B, i_ops_done,
        input  o_in_ready, o_out_valid, o_out_data, o_out_last, o_own_sram, o_addr_A,
               o_wr_en_A, o_write_data_A, o_addr_B, o_busy, o_overflow, o_timeout
    );
endinterface

// File: rtl/spmv_host_bridge.sv
// spmv_host_bridge: packs host words into SRAM A lines, arms the SpMV controller, streams SRAM B results.
// Optional WAIT watchdog enabled by defining SPMV_BRIDGE_TIMEOUT_EN.
module spmv_host_bridge #(
    parameter int ADDR_W    = 5,
    parameter int LINE_W    = 256,
    parameter int WORD_W    = 32,
    parameter int RES_LINES = 4
`ifdef SPMV_BRIDGE_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input logic              i_clk,
    input logic              i_rstn,
    spmv_host_bridge_if.slave bus
);
    localparam int LANES = LINE_W / WORD_W;
    localparam int LW    = $clog2(LANES);

    typedef enum logic [2:0] {IDLE, LOAD, ARM, WAIT, READ, CAPT, STREAM} state_e;

    state_e            state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d, wdata_q, wdata_d, cur_line, new_line;
    logic [LW-1:0]     lane_q, lane_d, cur_lane;
    logic [ADDR_W:0]   ptr_q, ptr_d, cur_ptr;
    logic [ADDR_W-1:0] waddr_q, waddr_d, r_q, r_d;
    logic              wr_q, wr_d, ovf_q, ovf_d, in_ready, in_acc, out_acc, lane_end, line_end;
`ifdef SPMV_BRIDGE_TIMEOUT_EN
    logic [16:0]       cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
`endif

    // The first word of a job starts from line 1, lane 0 regardless of leftover buffer state.
    always_comb begin
        in_ready = state_q == IDLE || state_q == LOAD;
        in_acc   = bus.i_in_valid && in_ready;
        out_acc  = state_q == STREAM && bus.i_out_ready;
        lane_end = lane_q == LW'(LANES - 1);
        line_end = r_q == ADDR_W'(RES_LINES - 1);
        cur_ptr  = state_q == IDLE ? (ADDR_W + 1)'(1) : ptr_q;
        cur_lane = state_q == IDLE ? '0 : lane_q;
        cur_line = state_q == IDLE ? '0 : line_q;
        new_line = cur_line;
        new_line[cur_lane*WORD_W +: WORD_W] = bus.i_in_data;
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        lane_d  = lane_q;
        ptr_d   = ptr_q;
        r_d     = r_q;
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
`ifdef SPMV_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE, LOAD: if (in_acc) begin
                if (state_q == IDLE) begin
                    ovf_d = 1'b0;
`ifdef SPMV_BRIDGE_TIMEOUT_EN
                    tmo_d = 1'b0;
`endif
                end
                state_d = bus.i_in_last ? ARM : LOAD;
                if (cur_ptr[ADDR_W]) begin
                    ovf_d = 1'b1;
                    ptr_d = cur_ptr;
                end else if (bus.i_in_last || cur_lane == LW'(LANES - 1)) begin
                    wr_d    = 1'b1;
                    waddr_d = cur_ptr[ADDR_W-1:0];
                    wdata_d = new_line;
                    line_d  = '0;
                    lane_d  = '0;
                    ptr_d   = cur_ptr + 1'b1;
                end else begin
                    line_d = new_line;
                    lane_d = cur_lane + 1'b1;
                    ptr_d  = cur_ptr;
                end
            end
            // A line write still pending from the last word takes the port first.
            ARM: if (!wr_q) begin
                state_d = WAIT;
                r_d     = '0;
`ifdef SPMV_BRIDGE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.i_ops_done) state_d = READ;
`ifdef SPMV_BRIDGE_TIMEOUT_EN
                else if (cnt_q + 17'd1 == 17'(TIMEOUT_CYCLES)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else cnt_d = cnt_q + 17'd1;
`endif
            end
            READ: state_d = CAPT;
            CAPT: begin
                line_d  = bus.i_read_data_B;
                lane_d  = '0;
                state_d = STREAM;
            end
            STREAM: if (out_acc) begin
                lane_d = lane_q + 1'b1;
                if (lane_end) begin
                    state_d = line_end ? IDLE : READ;
                    r_d     = r_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            line_q  <= '0;
            wdata_q <= '0;
            lane_q  <= '0;
            ptr_q   <= '0;
            waddr_q <= '0;
            r_q     <= '0;
            wr_q    <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SPMV_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
            ptr_q   <= ptr_d;
            waddr_q <= waddr_d;
            r_q     <= r_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
`ifdef SPMV_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.o_in_ready     = in_ready;
    assign bus.o_out_valid    = state_q == STREAM;
    assign bus.o_out_data     = line_q[lane_q*WORD_W +: WORD_W];
    assign bus.o_out_last     = state_q == STREAM && lane_end && line_end;
    assign bus.o_own_sram     = state_q != WAIT;
    assign bus.o_addr_A       = wr_q ? waddr_q : '0;
    assign bus.o_wr_en_A      = wr_q || state_q == ARM;
    assign bus.o_write_data_A = wr_q ? wdata_q : LINE_W'(state_q == ARM);
    assign bus.o_addr_B       = (state_q == READ || state_q == CAPT) ? r_q : '0;
    assign bus.o_busy         = state_q != IDLE;
    assign bus.o_overflow     = ovf_q;
`ifdef SPMV_BRIDGE_TIMEOUT_EN
    assign bus.o_timeout      = tmo_q;
`else
    assign bus.o_timeout      = 1'b0;
`endif
endmodule

// File: tb/tb_spmv_host_bridge.sv
// tb_spmv_host_bridge: directed bench for spmv_host_bridge with SRAM A/B models.
module tb_spmv_host_bridge;
    localparam int AW = 5, LW = 256, WW = 32, RL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spmv_host_bridge_if #(.ADDR_W(AW), .LINE_W(LW), .WORD_W(WW)) bus();

    spmv_host_bridge #(
        .ADDR_W(AW), .LINE_W(LW), .WORD_W(WW), .RES_LINES(RL)
`ifdef SPMV_BRIDGE_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (.i_clk(clk), .i_rstn(rst_n), .bus(bus));

    int vectors = 0, miscompares = 0;
    int cyc = 0, wr_cnt = 0, a0_cyc = -10;
    logic [LW-1:0] mem_a [32];
    logic [LW-1:0] mem_b [32];
    logic [LW-1:0] rd_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_q <= mem_b[bus.o_addr_B];
        if (bus.o_own_sram && bus.o_wr_en_A) begin
            mem_a[bus.o_addr_A] <= bus.o_write_data_A;
            wr_cnt <= wr_cnt + 1;
            if (bus.o_addr_A == 0) a0_cyc <= cyc;
        end
    end
    assign bus.i_read_data_B = rd_q;

    task automatic send_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_in_valid = 1'b1;
            bus.i_in_data  = base + 32'(i);
            bus.i_in_last  = (i == n - 1);
        end
        @(negedge clk);
        bus.i_in_valid = 1'b0;
        bus.i_in_last  = 1'b0;
    endtask

    task automatic wait_own_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.o_own_sram) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.i_in_valid = 0; bus.i_in_data = 0; bus.i_in_last = 0;
        bus.i_out_ready = 0; bus.i_ops_done = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (bus.o_own_sram !== 1'b1) begin miscompares++; $display("FAIL reset_own got=%b exp=1", bus.o_own_sram); end
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        vectors++; if (bus.o_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", bus.o_out_valid); end
        vectors++; if (bus.o_wr_en_A !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got=%b exp=0", bus.o_wr_en_A); end
        vectors++; if (bus.o_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", bus.o_overflow); end
        vectors++; if (bus.o_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got=%b exp=0", bus.o_timeout); end
        vectors++; if (bus.o_out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got=%b exp=0", bus.o_out_last); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_lines();
        int c0;
        bit ok;
        logic [LW-1:0] e1, e2;
        for (int k = 0; k < 8; k++) begin
            e1[k*WW +: WW] = 32'(k + 1);
            e2[k*WW +: WW] = 32'(k + 9);
        end
        c0 = wr_cnt;
        send_words(16, 32'h1);
        wait_own_low(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL full_own_fall got=timeout exp=own_low"); end
        vectors++; if (a0_cyc !== cyc - 1) begin miscompares++; $display("FAIL full_arm_timing got=%0d exp=%0d", a0_cyc, cyc - 1); end
        vectors++; if (wr_cnt - c0 !== 3) begin miscompares++; $display("FAIL full_write_count got=%0d exp=3", wr_cnt - c0); end
        vectors++; if (mem_a[1] !== e1) begin miscompares++; $display("FAIL full_line1 got=%h exp=%h", mem_a[1], e1); end
        vectors++; if (mem_a[2] !== e2) begin miscompares++; $display("FAIL full_line2 got=%h exp=%h", mem_a[2], e2); end
        vectors++; if (mem_a[0] !== LW'(1)) begin miscompares++; $display("FAIL full_start_flag got=%h exp=1", mem_a[0]); end
        vectors++; if (bus.o_overflow !== 1'b0) begin miscompares++; $display("FAIL full_overflow got=%b exp=0", bus.o_overflow); end
        vectors++; if (bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL full_busy got=%b exp=1", bus.o_busy); end
    endtask

    task automatic test_stream(input bit tog);
        int idx = 0;
        bit tgl = 1'b1, stalled = 1'b0, rdy;
        logic [WW-1:0] held = '0;
        @(negedge clk); bus.i_ops_done = 1'b1;
        @(negedge clk); bus.i_ops_done = 1'b0;
        for (int t = 0; t < 400 && idx < 32; t++) begin
            @(negedge clk);
            if (bus.o_out_valid) begin
                if (stalled) begin
                    vectors++; if (bus.o_out_data !== held) begin miscompares++; $display("FAIL stream_hold got=%h exp=%h", bus.o_out_data, held); end
                end
                rdy = tog ? tgl : 1'b1;
                tgl = !tgl;
                bus.i_out_ready = rdy;
                if (rdy) begin
                    vectors++; if (bus.o_out_data !== 32'(idx)) begin miscompares++; $display("FAIL stream_data[%0d] got=%h exp=%h", idx, bus.o_out_data, idx); end
                    vectors++; if (bus.o_out_last !== (idx == 31)) begin miscompares++; $display("FAIL stream_last[%0d] got=%b exp=%b", idx, bus.o_out_last, idx == 31); end
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = bus.o_out_data;
                end
            end else bus.i_out_ready = 1'b0;
        end
        vectors++; if (idx !== 32) begin miscompares++; $display("FAIL stream_count got=%0d exp=32", idx); end
        @(negedge clk);
        bus.i_out_ready = 1'b0;
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL stream_idle got=%b exp=0", bus.o_busy); end
        vectors++; if (bus.o_own_sram !== 1'b1) begin miscompares++; $display("FAIL stream_own got=%b exp=1", bus.o_own_sram); end
        vectors++; if (bus.o_out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_valid_after got=%b exp=0", bus.o_out_valid); end
    endtask

    task automatic test_overflow();
        int c0;
        bit ok;
        logic [LW-1:0] e1, e31;
        for (int k = 0; k < 8; k++) begin
            e1[k*WW +: WW]  = 32'(k + 1);
            e31[k*WW +: WW] = 32'(240 + k + 1);
        end
        c0 = wr_cnt;
        send_words(260, 32'h1);
        wait_own_low(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ovf_own_fall got=timeout exp=own_low"); end
        vectors++; if (a0_cyc !== cyc - 1) begin miscompares++; $display("FAIL ovf_arm_timing got=%0d exp=%0d", a0_cyc, cyc - 1); end
        vectors++; if (wr_cnt - c0 !== 32) begin miscompares++; $display("FAIL ovf_write_count got=%0d exp=32", wr_cnt - c0); end
        vectors++; if (mem_a[1] !== e1) begin miscompares++; $display("FAIL ovf_line1 got=%h exp=%h", mem_a[1], e1); end
        vectors++; if (mem_a[31] !== e31) begin miscompares++; $display("FAIL ovf_line31 got=%h exp=%h", mem_a[31], e31); end
        vectors++; if (mem_a[0] !== LW'(1)) begin miscompares++; $display("FAIL ovf_start_flag got=%h exp=1", mem_a[0]); end
        vectors++; if (bus.o_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b exp=1", bus.o_overflow); end
        test_stream(1'b0);
        vectors++; if (bus.o_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got=%b exp=1", bus.o_overflow); end
    endtask

    task automatic test_partial();
        int c0;
        bit ok;
        logic [LW-1:0] e;
        @(negedge clk); bus.i_ops_done = 1'b1;
        @(negedge clk); bus.i_ops_done = 1'b0;
        @(negedge clk);
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL done_ignored got=%b exp=0", bus.o_busy); end
        e = '0;
        e[95:0] = {32'hA3, 32'hA2, 32'hA1};
        c0 = wr_cnt;
        send_words(3, 32'hA1);
        wait_own_low(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL part_own_fall got=timeout exp=own_low"); end
        vectors++; if (wr_cnt - c0 !== 2) begin miscompares++; $display("FAIL part_write_count got=%0d exp=2", wr_cnt - c0); end
        vectors++; if (mem_a[1] !== e) begin miscompares++; $display("FAIL part_line1 got=%h exp=%h", mem_a[1], e); end
        vectors++; if (a0_cyc !== cyc - 1) begin miscompares++; $display("FAIL part_arm_timing got=%0d exp=%0d", a0_cyc, cyc - 1); end
        vectors++; if (bus.o_overflow !== 1'b0) begin miscompares++; $display("FAIL part_ovf_cleared got=%b exp=0", bus.o_overflow); end
    endtask

    task automatic test_midjob_reset();
        bit ok = 1'b0;
        @(negedge clk); bus.i_ops_done = 1'b1;
        @(negedge clk); bus.i_ops_done = 1'b0;
        bus.i_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL rst_reach_stream got=timeout exp=valid"); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.o_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%b exp=0", bus.o_out_valid); end
        vectors++; if (bus.o_own_sram !== 1'b1) begin miscompares++; $display("FAIL rst_own got=%b exp=1", bus.o_own_sram); end
        vectors++; if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", bus.o_busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wait();
        int n = 0;
        bit seen = 1'b0;
`ifdef SPMV_BRIDGE_TIMEOUT_EN
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (bus.o_out_valid) seen = 1'b1;
            if (!bus.o_busy) break;
        end
        vectors++; if (n !== 100) begin miscompares++; $display("FAIL timeout_cycles got=%0d exp=100", n); end
        vectors++; if (bus.o_timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_flag got=%b exp=1", bus.o_timeout); end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL timeout_no_output got=%b exp=0", seen); end
        vectors++; if (bus.o_own_sram !== 1'b1) begin miscompares++; $display("FAIL timeout_own got=%b exp=1", bus.o_own_sram); end
`else
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            n++;
            if (bus.o_out_valid || !bus.o_busy) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL wait_left_early got=%b exp=0", seen); end
        vectors++; if (bus.o_own_sram !== 1'b0) begin miscompares++; $display("FAIL wait_own got=%b exp=0", bus.o_own_sram); end
        vectors++; if (bus.o_timeout !== 1'b0) begin miscompares++; $display("FAIL wait_timeout got=%b exp=0", bus.o_timeout); end
        test_stream(1'b1);
`endif
    endtask

    initial begin
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 8; k++)
                mem_b[r][k*WW +: WW] = 32'(r * 8 + k);
        test_reset();
        test_full_lines();
        test_stream(1'b1);
        test_overflow();
        test_partial();
        test_midjob_reset();
        test_full_lines();
        test_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
